// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, byte width and parity-mode constants
// used by the arbiter, receiver and transmitter.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  localparam bit PARITY_MODE_EVEN = 1'b0;
  localparam bit PARITY_MODE_ODD  = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Rotate-priority encoder: first set request at or above ptr, wrapping to 0.
module rr_select #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  int                 sum;

  // Rotate so bit 0 is the requester at ptr, then scan from the top so the lowest offset wins.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N_REQ-1:0];
    valid = 1'b0;
    index = '0;
    sum   = 0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = int'(ptr) + i;
        if (sum >= int'(N_REQ)) sum = sum - int'(N_REQ);
        valid = 1'b1;
        index = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers,
// with parity generation and a start-handshake watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned DATA_W        = UART_DATA_W,
  parameter bit          PARITY_ODD    = PARITY_MODE_EVEN,
  parameter int unsigned START_TIMEOUT = 1023
) (
  input  logic                      CLOCK_125_p,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          grant,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_parity,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic                      active,
  output logic                      timeout_err
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned TO_W  = $clog2(START_TIMEOUT + 1);

  arb_state_t        state;
  logic [IDX_W-1:0]  ptr;
  logic [TO_W-1:0]   wdog;
  logic              sel_valid;
  logic [IDX_W-1:0]  sel_index;
  logic [DATA_W-1:0] sel_byte;
  logic [IDX_W-1:0]  next_ptr;

  rr_select #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_rr_select (
    .req  (req),
    .ptr  (ptr),
    .valid(sel_valid),
    .index(sel_index)
  );

  always_comb begin
    sel_byte = req_data[int'(sel_index)*DATA_W +: DATA_W];
    next_ptr = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
  end

  // Advancing ptr past owner on every exit keeps an aborted requester from being retried first.
  always_ff @(posedge CLOCK_125_p or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      wdog        <= '0;
      grant       <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      tx_parity   <= PARITY_ODD;
      active      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      grant    <= '0;
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            owner     <= sel_index;
            tx_data   <= sel_byte;
            tx_parity <= (^sel_byte) ^ PARITY_ODD;
            grant     <= N_REQ'(1) << sel_index;
            tx_start  <= 1'b1;
            active    <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          wdog  <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_done) begin
            ptr    <= next_ptr;
            active <= 1'b0;
            state  <= IDLE;
          end else if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (wdog == TO_W'(START_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            ptr         <= next_ptr;
            active      <= 1'b0;
            state       <= IDLE;
          end else begin
            wdog <= wdog + TO_W'(1);
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            ptr    <= next_ptr;
            active <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: even-parity and odd-parity instances share stimulus.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b0;

  logic [3:0]  grant_e, grant_o;
  logic        tx_start_e, tx_start_o;
  logic [7:0]  tx_data_e, tx_data_o;
  logic        tx_parity_e, tx_parity_o;
  logic [1:0]  owner_e, owner_o;
  logic        active_e, active_o;
  logic        timeout_err_e, timeout_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #4 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .PARITY_ODD(1'b0), .START_TIMEOUT(15)) dut_e (
    .CLOCK_125_p(clk), .reset(rst), .req(req), .req_data(req_data),
    .grant(grant_e), .tx_start(tx_start_e), .tx_data(tx_data_e), .tx_parity(tx_parity_e),
    .tx_busy(tx_busy), .tx_done(tx_done), .owner(owner_e), .active(active_e),
    .timeout_err(timeout_err_e)
  );

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .PARITY_ODD(1'b1), .START_TIMEOUT(15)) dut_o (
    .CLOCK_125_p(clk), .reset(rst), .req(req), .req_data(req_data),
    .grant(grant_o), .tx_start(tx_start_o), .tx_data(tx_data_o), .tx_parity(tx_parity_o),
    .tx_busy(tx_busy), .tx_done(tx_done), .owner(owner_o), .active(active_o),
    .timeout_err(timeout_err_o)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Starts at the LAUNCH sample; transmitter goes busy then done; returns at the IDLE sample.
  task automatic serve();
    tick();
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic wait_launch(output int w);
    w = 0;
    while (tx_start_e !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
  endtask

  task automatic test_reset();
    tick();
    n_checks++; if (grant_e !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant_e); end
    n_checks++; if (tx_start_e !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start_e); end
    n_checks++; if (tx_data_e !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data_e); end
    n_checks++; if (tx_parity_e !== 1'b0) begin n_fail++; $display("FAIL reset_parity_even: got %b want 0", tx_parity_e); end
    n_checks++; if (tx_parity_o !== 1'b1) begin n_fail++; $display("FAIL reset_parity_odd: got %b want 1", tx_parity_o); end
    n_checks++; if (owner_e !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner_e); end
    n_checks++; if (active_e !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", active_e); end
    n_checks++; if (timeout_err_e !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err_e); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int w;
    do_reset();
    req_data = 32'h0000_00A5;
    req = 4'b0001;
    wait_launch(w);
    n_checks++; if (w != 1) begin n_fail++; $display("FAIL single_latency: got %0d edges want 1", w); end
    n_checks++; if (grant_e !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", grant_e); end
    n_checks++; if (tx_data_e !== 8'hA5) begin n_fail++; $display("FAIL single_tx_data: got %h want a5", tx_data_e); end
    n_checks++; if (tx_parity_e !== 1'b0) begin n_fail++; $display("FAIL single_parity: got %b want 0", tx_parity_e); end
    n_checks++; if (active_e !== 1'b1) begin n_fail++; $display("FAIL single_active: got %b want 1", active_e); end
    req = 4'b0000;
    tick();
    n_checks++; if ({grant_e, tx_start_e} !== 5'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b/%b want 0000/0", grant_e, tx_start_e); end
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    n_checks++; if (active_e !== 1'b0) begin n_fail++; $display("FAIL single_idle: got active %b want 0", active_e); end
    // ptr should now be 1, so requester 1 beats requester 0.
    req_data = 32'h0000_7700;
    req = 4'b0011;
    wait_launch(w);
    n_checks++; if (grant_e !== 4'b0010) begin n_fail++; $display("FAIL single_ptr_adv: got %b want 0010", grant_e); end
    n_checks++; if (owner_e !== 2'd1) begin n_fail++; $display("FAIL single_owner: got %0d want 1", owner_e); end
    req = 4'b0000;
    serve();
  endtask

  task automatic test_fairness();
    logic [3:0] exp_gnt[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] exp_dat[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    int w;
    do_reset();
    req_data = 32'h4433_2211;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_launch(w);
      n_checks++; if (w != 1) begin n_fail++; $display("FAIL fair_b2b_latency[%0d]: got %0d edges want 1", g, w); end
      n_checks++; if (grant_e !== exp_gnt[g]) begin n_fail++; $display("FAIL fair_grant[%0d]: got %b want %b", g, grant_e, exp_gnt[g]); end
      n_checks++; if (tx_data_e !== exp_dat[g]) begin n_fail++; $display("FAIL fair_data[%0d]: got %h want %h", g, tx_data_e, exp_dat[g]); end
      if (g == 4) req = 4'b0000;
      serve();
    end
  endtask

  task automatic test_wrap();
    int w;
    do_reset();
    req_data = 32'h00AA_BBCC;
    req = 4'b0100;
    wait_launch(w);
    n_checks++; if (grant_e !== 4'b0100) begin n_fail++; $display("FAIL wrap_setup: got %b want 0100", grant_e); end
    req = 4'b0000;
    serve();
    req = 4'b0011;
    wait_launch(w);
    n_checks++; if (grant_e !== 4'b0001) begin n_fail++; $display("FAIL wrap_first: got %b want 0001", grant_e); end
    n_checks++; if (tx_data_e !== 8'hCC) begin n_fail++; $display("FAIL wrap_first_data: got %h want cc", tx_data_e); end
    req = 4'b0010;
    serve();
    wait_launch(w);
    n_checks++; if (grant_e !== 4'b0010) begin n_fail++; $display("FAIL wrap_second: got %b want 0010", grant_e); end
    n_checks++; if (tx_data_e !== 8'hBB) begin n_fail++; $display("FAIL wrap_second_data: got %h want bb", tx_data_e); end
    req = 4'b0000;
    serve();
  endtask

  task automatic test_done_priority();
    int w;
    do_reset();
    req_data = 32'h0000_3C5A;
    req = 4'b0001;
    wait_launch(w);
    req = 4'b0000;
    tick();
    tx_busy = 1'b1;
    tx_done = 1'b1;
    tick();
    tx_busy = 1'b0;
    tx_done = 1'b0;
    n_checks++; if (active_e !== 1'b0) begin n_fail++; $display("FAIL done_priority: got active %b want 0", active_e); end
    tick();
    n_checks++; if (active_e !== 1'b0) begin n_fail++; $display("FAIL done_priority_stay: got active %b want 0", active_e); end
    // tx_done in IDLE and LAUNCH must not end the next frame early.
    req = 4'b0010;
    tx_done = 1'b1;
    wait_launch(w);
    n_checks++; if (grant_e !== 4'b0010) begin n_fail++; $display("FAIL done_idle_grant: got %b want 0010", grant_e); end
    req = 4'b0000;
    tick();
    n_checks++; if (active_e !== 1'b1) begin n_fail++; $display("FAIL done_launch_ignored: got active %b want 1", active_e); end
    tx_done = 1'b0;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    n_checks++; if (active_e !== 1'b0) begin n_fail++; $display("FAIL done_from_wait_busy: got active %b want 0", active_e); end
  endtask

  task automatic test_watchdog();
    int w;
    do_reset();
    req_data = 32'h0000_6655;
    req = 4'b0011;
    wait_launch(w);
    n_checks++; if (grant_e !== 4'b0001) begin n_fail++; $display("FAIL wd_grant0: got %b want 0001", grant_e); end
    req = 4'b0010;
    for (int k = 1; k <= 15; k++) begin
      tick();
      n_checks++; if ({active_e, timeout_err_e} !== 2'b10) begin n_fail++; $display("FAIL wd_waiting[%0d]: got active/err %b%b want 10", k, active_e, timeout_err_e); end
    end
    tick();
    n_checks++; if ({active_e, timeout_err_e} !== 2'b01) begin n_fail++; $display("FAIL wd_abort: got active/err %b%b want 01", active_e, timeout_err_e); end
    wait_launch(w);
    n_checks++; if (w != 1) begin n_fail++; $display("FAIL wd_relaunch_latency: got %0d edges want 1", w); end
    n_checks++; if (grant_e !== 4'b0010) begin n_fail++; $display("FAIL wd_next_grant: got %b want 0010", grant_e); end
    n_checks++; if (tx_data_e !== 8'h66) begin n_fail++; $display("FAIL wd_next_data: got %h want 66", tx_data_e); end
    req = 4'b0000;
    serve();
    n_checks++; if ({active_e, timeout_err_e} !== 2'b01) begin n_fail++; $display("FAIL wd_sticky: got active/err %b%b want 01", active_e, timeout_err_e); end
  endtask

  task automatic test_reset_midframe();
    int w;
    req_data = 32'h0000_0001;
    req = 4'b0001;
    wait_launch(w);
    n_checks++; if (tx_parity_o !== 1'b0) begin n_fail++; $display("FAIL mid_parity_odd: got %b want 0", tx_parity_o); end
    n_checks++; if (tx_parity_e !== 1'b1) begin n_fail++; $display("FAIL mid_parity_even: got %b want 1", tx_parity_e); end
    req = 4'b0000;
    tick();
    tx_busy = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    n_checks++; if ({active_e, tx_start_e, grant_e} !== 6'b0) begin n_fail++; $display("FAIL mid_rst_ctrl: got %b%b%b want 000000", active_e, tx_start_e, grant_e); end
    n_checks++; if ({tx_data_e, owner_e} !== 10'b0) begin n_fail++; $display("FAIL mid_rst_data: got %h/%0d want 00/0", tx_data_e, owner_e); end
    n_checks++; if (timeout_err_e !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err: got %b want 0", timeout_err_e); end
    n_checks++; if (tx_parity_o !== 1'b1) begin n_fail++; $display("FAIL mid_rst_parity: got %b want 1", tx_parity_o); end
    tick();
    rst = 1'b0;
    tick();
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    n_checks++; if ({active_e, tx_start_e} !== 2'b00) begin n_fail++; $display("FAIL mid_stale_done: got %b%b want 00", active_e, tx_start_e); end
    req = 4'b0001;
    wait_launch(w);
    n_checks++; if (grant_o !== 4'b0001) begin n_fail++; $display("FAIL mid_relaunch_grant: got %b want 0001", grant_o); end
    n_checks++; if (tx_parity_o !== 1'b0) begin n_fail++; $display("FAIL mid_relaunch_parity: got %b want 0", tx_parity_o); end
    req = 4'b0000;
    serve();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_done_priority();
    test_watchdog();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete, got hang want finish");
    $fatal(1);
  end

endmodule
